basket_controller: RTL and testbench
====================================

BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, the number of basket slots (max 15).
REQ-002 The block SHALL have parameter NUM_PRODUCTS, default 12, the count of legal product IDs (0..NUM_PRODUCTS-1).
REQ-003 The block SHALL have parameter QTY_MAX, default 15, the per-slot quantity saturation value.
REQ-004 The block SHALL have one clock, CLOCK_50 (input, 1), and its asynchronous active-low reset RESET_N (input, 1).
REQ-005 The block SHALL have input Enable (1): one-cycle add request.
REQ-006 The block SHALL have input Cancel (1): one-cycle remove request.
REQ-007 The block SHALL have input Clear (1): one-cycle empty-basket request.
REQ-008 The block SHALL have input ProductID (4): product ID on Enable, slot index on Cancel.
REQ-009 The block SHALL have input ProductQuantity (4): quantity to add on Enable.
REQ-010 The block SHALL have input RdIndex (4): slot index for display readout.
REQ-011 The block SHALL have outputs RdProductID (4), RdQuantity (4) and RdValid (1): registered slot readout.
REQ-012 The block SHALL have output BasketProductNum (4): number of occupied slots.
REQ-013 The block SHALL have outputs Busy (1), Full (1) and Error (1): Error is a one-cycle rejected-request pulse.

Function
REQ-014 FSM states SHALL be IDLE, SEARCH and SHIFT; Busy SHALL be 1 in every state except IDLE.
REQ-015 Slots 0..BasketProductNum-1 SHALL always be occupied and contiguous; unoccupied slots SHALL hold ID 0, qty 0.
REQ-016 Enable in IDLE SHALL latch ProductID/ProductQuantity. If qty==0 or ID>=NUM_PRODUCTS, Error SHALL pulse next cycle and the FSM stays IDLE; otherwise go to SEARCH with ptr=0.
REQ-017 SEARCH, ptr<count, slot[ptr].ID==latched ID: slot qty <= min(qty+latched qty, QTY_MAX) using 5-bit sum, then go to IDLE.
REQ-018 SEARCH, ptr<count, no match: ptr SHALL increment (one slot per cycle).
REQ-019 SEARCH, ptr==count: if count<DEPTH, write slot[count], increment count, go to IDLE; else pulse Error, basket unchanged, go to IDLE.
REQ-020 Cancel in IDLE with ProductID<count SHALL go to SHIFT with ptr=ProductID; with ProductID>=count, Error SHALL pulse and the basket is unchanged.
REQ-021 SHIFT, ptr<count-1: slot[ptr] <= slot[ptr+1], ptr++; at ptr==count-1: zero slot[ptr], decrement count, go to IDLE.
REQ-022 Enable and Cancel together in IDLE: Cancel SHALL be served, the Enable dropped and Error pulsed.
REQ-023 Enable or Cancel while Busy SHALL be ignored and pulse Error; in-flight operation continues.
REQ-024 Clear SHALL take priority in any state: next edge zeroes all slots and count, FSM to IDLE, no Error; any in-flight operation is aborted.
REQ-025 Full SHALL equal (count==DEPTH), combinational from the count register.
REQ-026 Readout SHALL have 1-cycle latency: RdValid <= (RdIndex<count); RdProductID/RdQuantity <= slot[RdIndex] if valid, else 0.
REQ-027 Readout SHALL reflect slot contents as of the previous edge, including mid-SHIFT intermediate states.

Reset
REQ-028 RESET_N low SHALL immediately clear all slots, count, ptr, latched inputs and readout registers, set FSM to IDLE, and drive Busy=0, Full=0, Error=0, RdValid=0, BasketProductNum=0.
REQ-029 Reset asserted mid-SEARCH or mid-SHIFT SHALL discard the operation; first request after release is accepted normally.

Verification
REQ-030 Empty basket, Enable ID=3 qty=2 at cycle 0 -> Busy=1 at cycle 1, BasketProductNum=1 at cycle 2, RdIndex=0 then gives ID 3, qty 2.
REQ-031 Slots {3:2,5:1,7:4}, Enable ID=7 qty=4 -> count stays 3, slot2 qty=8, done after 4 cycles; repeat twice more -> qty saturates at 15.
REQ-032 Slots {3,5,7,9}, Cancel index=1 -> after 3 SHIFT cycles slots {3,7,9}, count=3, slot3 zero.
REQ-033 Fill 8 distinct IDs, Enable new ID=11 -> Error pulse once, count=8, Full=1; Enable ID=12 or qty=0 -> Error, no change.
REQ-034 Enable during SEARCH and Cancel index=count -> Error each, basket unchanged; Clear mid-SHIFT -> count=0 next cycle, Busy=0.
REQ-035 RESET_N pulsed low mid-SEARCH -> all outputs 0 immediately; next Enable ID=0 qty=1 -> count=1.

Source files
------------

// File: rtl/basket_controller.sv
// basket_controller: shopping-basket slot store with add/merge, remove-with-compaction, clear and readout
// Ports: CLOCK_50 / RESET_N clock and asynchronous active-low reset;
//   Enable / Cancel / Clear one-cycle add, remove and empty requests;
//   ProductID (product on Enable, slot index on Cancel), ProductQuantity (amount to add);
//   RdIndex -> RdProductID / RdQuantity / RdValid registered slot readout;
//   BasketProductNum occupied slots, Busy (operation in flight), Full, Error (one-cycle reject pulse).
module basket_controller #(
    parameter int DEPTH        = 8,
    parameter int NUM_PRODUCTS = 12,
    parameter int QTY_MAX      = 15
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       Enable,
    input  logic       Cancel,
    input  logic       Clear,
    input  logic [3:0] ProductID,
    input  logic [3:0] ProductQuantity,
    input  logic [3:0] RdIndex,
    output logic [3:0] RdProductID,
    output logic [3:0] RdQuantity,
    output logic       RdValid,
    output logic [3:0] BasketProductNum,
    output logic       Busy,
    output logic       Full,
    output logic       Error
);
    typedef enum logic [1:0] {IDLE, SEARCH, SHIFT} state_t;
    localparam logic [3:0] DP = 4'(DEPTH);
    localparam logic [4:0] NP = 5'(NUM_PRODUCTS);
    localparam logic [4:0] QM = 5'(QTY_MAX);
    state_t state, state_d;
    // Arrays span the full 4-bit index range so any ptr/RdIndex is a legal index;
    // entries at or above DEPTH are never written and stay zero.
    logic [3:0] slot_id [16];
    logic [3:0] slot_qty [16];
    logic [3:0] ptr, lat_id, lat_qty;
    logic [4:0] sum;
    logic       hit, at_end, req_ok, cancel_ok, last;
    assign at_end    = ptr == BasketProductNum;
    assign hit       = slot_id[ptr] == lat_id;
    assign last      = ptr == BasketProductNum - 4'd1;
    assign req_ok    = ProductQuantity != 4'd0 && {1'b0, ProductID} < NP;
    assign cancel_ok = ProductID < BasketProductNum;
    assign sum       = {1'b0, slot_qty[ptr]} + {1'b0, lat_qty};
    assign Full      = BasketProductNum == DP;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) state <= IDLE;
        else          state <= state_d;
    // at_end is tested before hit: the empty slot at index count holds ID 0 and must not match
    always_comb begin
        state_d = state;
        if (Clear)                state_d = IDLE;
        else if (state == IDLE)   state_d = Cancel ? (cancel_ok ? SHIFT : IDLE) : (Enable && req_ok) ? SEARCH : IDLE;
        else if (state == SEARCH) state_d = (at_end || hit) ? IDLE : SEARCH;
        else                      state_d = last ? IDLE : SHIFT;
    end
    always_comb Busy = state != IDLE;
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) begin
                slot_id[i]  <= '0;
                slot_qty[i] <= '0;
            end
            BasketProductNum <= '0;
            ptr              <= '0;
            lat_id           <= '0;
            lat_qty          <= '0;
            Error            <= 1'b0;
        end else if (Clear) begin
            for (int i = 0; i < 16; i++) begin
                slot_id[i]  <= '0;
                slot_qty[i] <= '0;
            end
            BasketProductNum <= '0;
            ptr              <= '0;
            Error            <= 1'b0;
        end else if (state == IDLE) begin
            // Cancel wins over a simultaneous Enable, which is dropped and flagged
            Error <= Cancel ? (Enable || !cancel_ok) : (Enable && !req_ok);
            if (Cancel)
                ptr <= ProductID;
            else if (Enable) begin
                ptr     <= '0;
                lat_id  <= ProductID;
                lat_qty <= ProductQuantity;
            end
        end else if (state == SEARCH) begin
            Error <= Enable || Cancel || (at_end && Full);
            if (at_end) begin
                if (!Full) begin
                    slot_id[ptr]     <= lat_id;
                    slot_qty[ptr]    <= lat_qty;
                    BasketProductNum <= BasketProductNum + 4'd1;
                end
            end else if (hit)
                slot_qty[ptr] <= sum > QM ? QM[3:0] : sum[3:0];
            else
                ptr <= ptr + 4'd1;
        end else begin
            Error <= Enable || Cancel;
            // compaction: pull each later slot down one place, then clear the vacated tail
            if (last) begin
                slot_id[ptr]     <= '0;
                slot_qty[ptr]    <= '0;
                BasketProductNum <= BasketProductNum - 4'd1;
            end else begin
                slot_id[ptr]  <= slot_id[ptr + 4'd1];
                slot_qty[ptr] <= slot_qty[ptr + 4'd1];
                ptr           <= ptr + 4'd1;
            end
        end
    end
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            RdValid     <= 1'b0;
            RdProductID <= '0;
            RdQuantity  <= '0;
        end else begin
            RdValid     <= RdIndex < BasketProductNum;
            RdProductID <= RdIndex < BasketProductNum ? slot_id[RdIndex] : '0;
            RdQuantity  <= RdIndex < BasketProductNum ? slot_qty[RdIndex] : '0;
        end
endmodule

// File: tb/tb_basket_controller.sv
// tb_basket_controller: directed stimulus, transaction-level basket model and per-cycle output compare
module tb_basket_controller;
    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       Enable = 1'b0, Cancel = 1'b0, Clear = 1'b0;
    logic [3:0] ProductID = '0, ProductQuantity = '0, RdIndex = '0;
    logic [3:0] RdProductID, RdQuantity, BasketProductNum;
    logic       RdValid, Busy, Full, Error;
    int checks = 0;
    int errors = 0;
    basket_controller dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
        .Enable(Enable), .Cancel(Cancel), .Clear(Clear),
        .ProductID(ProductID), .ProductQuantity(ProductQuantity), .RdIndex(RdIndex),
        .RdProductID(RdProductID), .RdQuantity(RdQuantity), .RdValid(RdValid),
        .BasketProductNum(BasketProductNum), .Busy(Busy), .Full(Full), .Error(Error)
    );
    always #10 CLOCK_50 = ~CLOCK_50;
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask
    // Model: the basket is an ordered list of (id, qty). An accepted request stays busy for the
    // number of cycles its scan or compaction needs, and its effect on the list lands on the last one.
    int  q_id[$], q_qty[$];
    int  busy_cnt = 0, total = 0, op = 0, p_id = 0, p_qty = 0, p_idx = 0, k = 0;
    int  rdid_e = 0, rdq_e = 0;
    bit  err_e = 0, rdv_e = 0, rd_known = 1;
    function automatic int find(input int id);
        foreach (q_id[i]) if (q_id[i] == id) return i;
        return -1;
    endfunction
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            q_id.delete();
            q_qty.delete();
            busy_cnt = 0;
            err_e = 0;
            rdv_e = 0;
            rdid_e = 0;
            rdq_e = 0;
            rd_known = 1;
        end else begin
            rdv_e  = int'(RdIndex) < q_id.size();
            rdid_e = rdv_e ? q_id[RdIndex] : 0;
            rdq_e  = rdv_e ? q_qty[RdIndex] : 0;
            // mid-removal the slots hold partially compacted data the list model does not track
            rd_known = !(busy_cnt > 0 && op == 1 && busy_cnt < total);
            err_e = 0;
            if (Clear) begin
                q_id.delete();
                q_qty.delete();
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                err_e = Enable || Cancel;
                busy_cnt--;
                if (busy_cnt == 0) begin
                    if (op == 1) begin
                        q_id.delete(p_idx);
                        q_qty.delete(p_idx);
                    end else begin
                        k = find(p_id);
                        if (k >= 0) q_qty[k] = (q_qty[k] + p_qty > 15) ? 15 : q_qty[k] + p_qty;
                        else if (q_id.size() < 8) begin
                            q_id.push_back(p_id);
                            q_qty.push_back(p_qty);
                        end else err_e = 1;
                    end
                end
            end else if (Cancel) begin
                err_e = Enable || int'(ProductID) >= q_id.size();
                if (int'(ProductID) < q_id.size()) begin
                    op = 1;
                    p_idx = int'(ProductID);
                    total = q_id.size() - p_idx;
                    busy_cnt = total;
                end
            end else if (Enable) begin
                if (ProductQuantity == 0 || ProductID >= 12) err_e = 1;
                else begin
                    op = 0;
                    p_id = int'(ProductID);
                    p_qty = int'(ProductQuantity);
                    k = find(p_id);
                    busy_cnt = k >= 0 ? k + 1 : q_id.size() + 1;
                    total = busy_cnt;
                end
            end
        end
    end
    always @(negedge CLOCK_50) begin
        chk("busy", Busy, int'(busy_cnt > 0));
        chk("count", BasketProductNum, q_id.size());
        chk("full", Full, int'(q_id.size() == 8));
        chk("error", Error, err_e);
        chk("rd_valid", RdValid, rdv_e);
        if (rd_known) begin
            chk("rd_id", RdProductID, rdid_e);
            chk("rd_qty", RdQuantity, rdq_e);
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLOCK_50);
    endtask
    task automatic req(input bit en, input bit can, input int id, input int qty);
        Enable = en;
        Cancel = can;
        ProductID = 4'(id);
        ProductQuantity = 4'(qty);
        tick();
        Enable = 1'b0;
        Cancel = 1'b0;
    endtask
    task automatic wait_idle(output int errs);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (Error) errs++;
            if (!Busy) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout busy still %0d after 40 cycles", Busy);
    endtask
    task automatic add(input int id, input int qty);
        int e;
        req(1, 0, id, qty);
        wait_idle(e);
    endtask
    task automatic clear();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask
    task automatic rd(input int idx, input string n, input int id, input int qty, input int v);
        RdIndex = 4'(idx);
        tick();
        chk({n, "_valid"}, RdValid, v);
        chk({n, "_id"}, RdProductID, id);
        chk({n, "_qty"}, RdQuantity, qty);
    endtask
    initial begin
        int e;
        tick(2);
        chk("reset_busy", Busy, 0);
        chk("reset_count", BasketProductNum, 0);
        chk("reset_full", Full, 0);
        chk("reset_error", Error, 0);
        chk("reset_rdvalid", RdValid, 0);
        RESET_N = 1'b1;
        tick();
        // first add into an empty basket
        req(1, 0, 3, 2);
        chk("add1_busy", Busy, 1);
        chk("add1_count_early", BasketProductNum, 0);
        tick();
        chk("add1_count", BasketProductNum, 1);
        chk("add1_idle", Busy, 0);
        rd(0, "add1_rd", 3, 2, 1);
        // merge into slot 2 and saturate
        add(5, 1);
        add(7, 4);
        req(1, 0, 7, 4);
        tick(2);
        chk("merge_busy", Busy, 1);
        tick();
        chk("merge_done", Busy, 0);
        chk("merge_count", BasketProductNum, 3);
        rd(2, "merge_rd", 7, 8, 1);
        add(7, 4);
        add(7, 4);
        rd(2, "sat_rd", 7, 15, 1);
        // remove slot 1 of four, watching the intermediate compaction state
        clear();
        chk("clear_count", BasketProductNum, 0);
        add(3, 1);
        add(5, 1);
        add(7, 1);
        add(9, 1);
        RdIndex = 4'd1;
        tick();
        req(0, 1, 1, 0);
        tick();
        chk("shift_rd_e1", RdProductID, 5);
        tick();
        chk("shift_rd_mid", RdProductID, 7);
        chk("shift_busy", Busy, 1);
        tick();
        chk("shift_done", Busy, 0);
        chk("shift_count", BasketProductNum, 3);
        rd(3, "shift_tail", 0, 0, 0);
        rd(0, "shift_s0", 3, 1, 1);
        rd(1, "shift_s1", 7, 1, 1);
        rd(2, "shift_s2", 9, 1, 1);
        // full basket
        clear();
        for (int i = 0; i < 8; i++) add(i, 1);
        chk("fill_full", Full, 1);
        req(1, 0, 11, 1);
        wait_idle(e);
        chk("full_err_pulses", e, 1);
        chk("full_count", BasketProductNum, 8);
        req(1, 0, 12, 1);
        chk("bad_id_err", Error, 1);
        req(1, 0, 5, 0);
        chk("zero_qty_err", Error, 1);
        chk("bad_count", BasketProductNum, 8);
        rd(5, "bad_rd", 5, 1, 1);
        // requests while busy, out-of-range cancel, clear mid-shift
        clear();
        add(3, 1);
        add(5, 1);
        add(7, 1);
        req(1, 0, 9, 2);
        req(1, 0, 4, 1);
        chk("busy_en_err", Error, 1);
        wait_idle(e);
        chk("busy_en_count", BasketProductNum, 4);
        rd(3, "busy_rd3", 9, 2, 1);
        rd(4, "busy_rd4", 0, 0, 0);
        req(0, 1, 4, 0);
        chk("cancel_oor_err", Error, 1);
        chk("cancel_oor_count", BasketProductNum, 4);
        req(0, 1, 0, 0);
        chk("clrmid_busy_before", Busy, 1);
        clear();
        chk("clrmid_count", BasketProductNum, 0);
        chk("clrmid_busy", Busy, 0);
        chk("clrmid_err", Error, 0);
        // simultaneous Enable and Cancel
        add(3, 1);
        add(5, 1);
        req(1, 1, 0, 1);
        chk("both_err", Error, 1);
        wait_idle(e);
        chk("both_count", BasketProductNum, 1);
        rd(0, "both_rd", 5, 1, 1);
        // asynchronous reset mid-search
        add(3, 1);
        req(1, 0, 6, 1);
        tick();
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_count", BasketProductNum, 0);
        chk("rst_full", Full, 0);
        chk("rst_error", Error, 0);
        chk("rst_rdvalid", RdValid, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        add(0, 1);
        chk("post_rst_count", BasketProductNum, 1);
        rd(0, "post_rst_rd", 0, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
